// File: rtl/subtractorfp32_seq_if.sv
// Operand/result handshake bundle for subtractorfp32_seq.
// The master side drives operands and out_ready; the slave side is the subtractor.
interface subtractorfp32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] o;
  logic [2:0]  flags;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, o, flags, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, o, flags, busy
  );
endinterface

// File: rtl/subtractorfp32_seq.sv
// Multi-cycle FP32 subtractor O = A - B, normalising one bit per cycle.
// Define FP32SUB_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module subtractorfp32_seq (
  input  logic                  clk,
  input  logic                  rst,
  subtractorfp32_seq_if.slave   bus
);

  // The alignment shift is registered by the capture edge itself, so the
  // first working state after accept is already the add.
  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

  typedef struct packed {
    logic [31:0] o;
    logic [2:0]  flags;
  } res_t;

  state_t      state_q, state_d;
  logic [31:0] o_q, o_d;
  logic [2:0]  flags_q, flags_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic [8:0]  exp_q, exp_d;
  logic [26:0] big_q, big_d;      // {24 mantissa, G, R, S}
  logic [26:0] small_q, small_d;
  logic [27:0] man_q, man_d;      // carry bit on top of the 27-bit field
  res_t        res;

  // Operand decode at capture; b's sign is flipped so the rest is an addition.
  logic        sb, a_nan, b_nan, a_inf, b_inf, a_ge_b, accept;
  logic [7:0]  exp_a, exp_b, big_e, small_e, diff;
  logic [23:0] man_a, man_b, big_m, small_m;
  logic        big_s, small_s;
  logic [53:0] shift_ext;
  logic [26:0] aligned;

  assign sb      = ~bus.b[31];
  assign a_nan   = (&bus.a[30:23]) && (bus.a[22:0] != 23'd0);
  assign b_nan   = (&bus.b[30:23]) && (bus.b[22:0] != 23'd0);
  assign a_inf   = (&bus.a[30:23]) && (bus.a[22:0] == 23'd0);
  assign b_inf   = (&bus.b[30:23]) && (bus.b[22:0] == 23'd0);
  assign exp_a   = (bus.a[30:23] == 8'd0) ? 8'd1 : bus.a[30:23];
  assign exp_b   = (bus.b[30:23] == 8'd0) ? 8'd1 : bus.b[30:23];
  assign man_a   = {|bus.a[30:23], bus.a[22:0]};
  assign man_b   = {|bus.b[30:23], bus.b[22:0]};
  assign a_ge_b  = {exp_a, man_a} >= {exp_b, man_b};
  assign big_s   = a_ge_b ? bus.a[31] : sb;
  assign small_s = a_ge_b ? sb : bus.a[31];
  assign big_e   = a_ge_b ? exp_a : exp_b;
  assign small_e = a_ge_b ? exp_b : exp_a;
  assign big_m   = a_ge_b ? man_a : man_b;
  assign small_m = a_ge_b ? man_b : man_a;
  assign diff    = big_e - small_e;

  // Bits pushed below the 27-bit field collapse into S.
  assign shift_ext = {small_m, 30'd0} >> diff;
  assign aligned   = (diff >= 8'd27) ? {26'd0, |small_m}
                                     : {shift_ext[53:28], shift_ext[27] | (|shift_ext[26:0])};

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.o         = o_q;
  assign bus.flags     = flags_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // Final packing: optional rounding, overflow to inf, subnormal emission.
  function automatic res_t pack(input logic s, input logic [8:0] e, input logic [23:0] m,
                                input logic g, input logic r, input logic st);
    res_t        p;
    logic [24:0] mr;
    logic [8:0]  er;
    logic        up;
`ifdef FP32SUB_ROUND_EN
    up = g & (r | st | m[0]);
`else
    up = 1'b0 & g & (r | st | m[0]);  // truncation: increment tied off
`endif
    mr = {1'b0, m} + {24'd0, up};
    er = e;
    if (mr[24]) begin
      mr = 25'h0800000;
      er = e + 9'd1;
    end
    if (er >= 9'd255) begin
      p.o     = {s, 8'hFF, 23'd0};
      p.flags = 3'b010;
    end else begin
      p.o     = {s, (mr[23] ? er[7:0] : 8'd0), mr[22:0]};
      p.flags = {2'b00, mr[23:0] == 24'd0};
    end
    return p;
  endfunction

  // NOTE: every variable written here gets its hold value first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    flags_d = flags_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    man_d   = man_q;
    res     = '0;
    unique case (state_q)
      IDLE: if (accept) begin
        if (a_nan || b_nan || (a_inf && b_inf && (bus.a[31] != sb))) begin
          o_d = 32'h7FC0_0000; flags_d = 3'b100; state_d = DONE;
        end else if (a_inf) begin
          o_d = {bus.a[31], 8'hFF, 23'd0}; flags_d = 3'b010; state_d = DONE;
        end else if (b_inf) begin
          o_d = {sb, 8'hFF, 23'd0}; flags_d = 3'b010; state_d = DONE;
        end else begin
          sign_d  = big_s;
          sub_d   = big_s ^ small_s;
          exp_d   = {1'b0, big_e};
          big_d   = {big_m, 3'b000};
          small_d = aligned;
          state_d = ADD;
        end
      end
      ADD: begin
        man_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        state_d = NORM;
      end
      NORM: begin
        if (man_q[27]) begin
          res = pack(sign_q, exp_q + 9'd1, man_q[27:4], man_q[3], man_q[2], |man_q[1:0]);
          o_d = res.o; flags_d = res.flags; state_d = DONE;
        end else if (man_q == 28'd0) begin
          o_d = 32'd0; flags_d = 3'b001; state_d = DONE;
        end else if (!man_q[26] && (exp_q > 9'd1)) begin
          man_d = {man_q[26:0], 1'b0};
          exp_d = exp_q - 9'd1;
        end else begin
          res = pack(sign_q, exp_q, man_q[26:3], man_q[2], man_q[1], man_q[0]);
          o_d = res.o; flags_d = res.flags; state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      o_q     <= 32'd0;
      flags_q <= 3'd0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      flags_q <= flags_d;
    end
  end

  // NOTE: datapath registers are left unreset; a capture always overwrites them before use.
  always_ff @(posedge clk) begin
    sign_q  <= sign_d;
    sub_q   <= sub_d;
    exp_q   <= exp_d;
    big_q   <= big_d;
    small_q <= small_d;
    man_q   <= man_d;
  end

endmodule
